// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the EX-stage hazard controller:
// forwarding select encoding, shadow pipeline entry and counter helper.
package ex_hazard_ctrl_pkg;

    localparam int unsigned REGW = 5;
    localparam int unsigned CNTW = 16;

    // Zero register: reads as zero, so it can never be a real producer.
    localparam logic [REGW-1:0] XZR = REGW'(31);

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rn;
        logic [REGW-1:0] rm;
        logic            uses_rm;
        logic [REGW-1:0] rd;
        logic            regwrite;
        logic            memread;
    } stage_info_t;

    localparam stage_info_t STAGE_BUBBLE = '0;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] cnt,
                                                input logic            inc);
        if (inc && (cnt != {CNTW{1'b1}})) begin
            return cnt + CNTW'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ID-stage hazard inputs and the stall/flush/forward controls back to the pipeline.
// master = pipeline side driving ID info, slave = hazard controller.
interface ex_hazard_ctrl_if;
    import ex_hazard_ctrl_pkg::*;

    logic            id_valid;
    logic [REGW-1:0] id_rn;
    logic [REGW-1:0] id_rm;
    logic            id_uses_rm;
    logic [REGW-1:0] id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic            mem_pcsrc;

    logic            stall_F;
    logic            stall_D;
    logic            flush_D;
    logic            flush_E;
    logic            flush_M;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_uses_rm, id_rd, id_regwrite, id_memread,
        output mem_pcsrc,
        input  stall_F, stall_D, flush_D, flush_E, flush_M,
        input  fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_uses_rm, id_rd, id_regwrite, id_memread,
        input  mem_pcsrc,
        output stall_F, stall_D, flush_D, flush_E, flush_M,
        output fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// Picks the ALU operand source for one EX register read: the youngest
// in-flight producer (MEM, then WB) wins, else the register file.
module ex_hazard_ctrl_fwd_sel
    import ex_hazard_ctrl_pkg::*;
(
    input  logic            i_e_valid,
    input  logic [REGW-1:0] i_src,
    input  stage_info_t     i_m,
    input  stage_info_t     i_w,
    output fwd_sel_t        o_sel
);

    logic w_m_hit;
    logic w_w_hit;
    logic w_unused;

    // A load in MEM has no data yet; its value is picked up from WB a cycle later.
    assign w_m_hit = i_m.valid && i_m.regwrite && !i_m.memread &&
                     (i_m.rd != XZR) && (i_m.rd == i_src);
    assign w_w_hit = i_w.valid && i_w.regwrite &&
                     (i_w.rd != XZR) && (i_w.rd == i_src);

    always_comb begin
        o_sel = FWD_RF;
        if (i_e_valid) begin
            if (w_m_hit) begin
                o_sel = FWD_MEM;
            end else if (w_w_hit) begin
                o_sel = FWD_WB;
            end
        end
    end

    assign w_unused = ^{i_m.rn, i_m.rm, i_m.uses_rm,
                        i_w.rn, i_w.rm, i_w.uses_rm, i_w.memread};

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadows E/M/W destination info, drives operand
// forwarding, load-use stalls, taken-branch flushes and saturating event counters.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    ex_hazard_ctrl_if.slave  hz
);

    stage_info_t     r_e;
    stage_info_t     r_m;
    stage_info_t     r_w;
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    stage_info_t     w_id;
    logic            w_lu;
    logic            w_stall_F;
    logic            w_stall_D;
    logic            w_flush_D;
    logic            w_flush_E;
    logic            w_flush_M;
    fwd_sel_t        w_fwd_a;
    fwd_sel_t        w_fwd_b;
    logic            w_unused;

    always_comb begin
        w_id          = STAGE_BUBBLE;
        w_id.valid    = hz.id_valid;
        w_id.rn       = hz.id_rn;
        w_id.rm       = hz.id_rm;
        w_id.uses_rm  = hz.id_uses_rm;
        w_id.rd       = hz.id_rd;
        w_id.regwrite = hz.id_regwrite;
        w_id.memread  = hz.id_memread;
    end

    // Load in EX whose result the ID instruction needs next cycle.
    assign w_lu = r_e.valid && r_e.memread && r_e.regwrite && (r_e.rd != XZR) &&
                  hz.id_valid &&
                  ((hz.id_rn == r_e.rd) || (hz.id_uses_rm && (hz.id_rm == r_e.rd)));

    // A taken branch squashes everything younger, including a pending load-use stall.
    always_comb begin
        w_stall_F = 1'b0;
        w_stall_D = 1'b0;
        w_flush_D = 1'b0;
        w_flush_E = 1'b0;
        w_flush_M = 1'b0;
        if (hz.mem_pcsrc) begin
            w_flush_D = 1'b1;
            w_flush_E = 1'b1;
            w_flush_M = 1'b1;
        end else if (w_lu) begin
            w_stall_F = 1'b1;
            w_stall_D = 1'b1;
            w_flush_E = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e <= STAGE_BUBBLE;
            r_m <= STAGE_BUBBLE;
            r_w <= STAGE_BUBBLE;
        end else begin
            r_w <= r_m;
            if (hz.mem_pcsrc) begin
                r_m <= STAGE_BUBBLE;
                r_e <= STAGE_BUBBLE;
            end else if (w_lu) begin
                r_m <= r_e;
                r_e <= STAGE_BUBBLE;
            end else begin
                r_m <= r_e;
                r_e <= w_id;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_stall_cnt <= sat_inc(r_stall_cnt, w_stall_F);
            r_flush_cnt <= sat_inc(r_flush_cnt, hz.mem_pcsrc);
        end
    end

    ex_hazard_ctrl_fwd_sel u_fwd_a (
        .i_e_valid (r_e.valid),
        .i_src     (r_e.rn),
        .i_m       (r_m),
        .i_w       (r_w),
        .o_sel     (w_fwd_a)
    );

    ex_hazard_ctrl_fwd_sel u_fwd_b (
        .i_e_valid (r_e.valid),
        .i_src     (r_e.rm),
        .i_m       (r_m),
        .i_w       (r_w),
        .o_sel     (w_fwd_b)
    );

    assign hz.stall_F   = w_stall_F;
    assign hz.stall_D   = w_stall_D;
    assign hz.flush_D   = w_flush_D;
    assign hz.flush_E   = w_flush_E;
    assign hz.flush_M   = w_flush_M;
    assign hz.fwd_a     = w_fwd_a;
    assign hz.fwd_b     = w_fwd_b;
    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;

    // Load-use only looks at the ID instruction's own uses_rm flag.
    assign w_unused = r_e.uses_rm;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: random traffic against an instruction-level model,
// a directed program table, mid-stream reset and counter saturation.
module tb_ex_hazard_ctrl;

    localparam int CMAX = 65535;
    localparam logic [4:0] ZR = 5'd31;

    logic clk;
    logic reset;

    ex_hazard_ctrl_if hz();

    ex_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       urm;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    typedef struct {
        ins_t       id;
        logic       pc;
        logic [4:0] ctl;   // {stall_F, stall_D, flush_D, flush_E, flush_M}
        logic [1:0] fa;
        logic [1:0] fb;
        int         scnt;
        int         fcnt;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    // Model: the three instructions in flight after ID, plus event tallies.
    ins_t pe, pm, pw;
    int   m_scnt, m_fcnt;

    function automatic ins_t mk(input logic v, input int rn, input int rm, input logic urm,
                                input int rd, input logic rw, input logic mr);
        ins_t r;
        r.v = v; r.rn = 5'(rn); r.rm = 5'(rm); r.urm = urm;
        r.rd = 5'(rd); r.rw = rw; r.mr = mr;
        return r;
    endfunction

    function automatic ins_t nop();
        return mk(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endfunction

    function automatic logic [4:0] rnd_reg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? ZR : 5'(k);
    endfunction

    function automatic ins_t rnd_ins();
        return mk($urandom_range(0, 3) != 0, int'(rnd_reg()), int'(rnd_reg()),
                  1'($urandom_range(0, 1)), int'(rnd_reg()),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    endfunction

    // ID must wait if it reads the target of a load whose data does not exist yet.
    function automatic logic m_lu(input ins_t id);
        if (!(pe.v && pe.mr && pe.rw) || pe.rd == ZR || !id.v) return 1'b0;
        return (id.rn == pe.rd) || (id.urm && id.rm == pe.rd);
    endfunction

    // Scan older instructions youngest-first for the one that wrote src.
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        ins_t prod [2];
        if (!pe.v || src == ZR) return 2'b00;
        prod[0] = pm;
        prod[1] = pw;
        for (int i = 0; i < 2; i++) begin
            if (prod[i].v && prod[i].rw && prod[i].rd == src && !(i == 0 && prod[i].mr))
                return (i == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic [4:0] m_ctl(input ins_t id, input logic pc);
        if (pc) return 5'b00111;
        if (m_lu(id)) return 5'b11010;
        return 5'b00000;
    endfunction

    task automatic m_reset();
        pe = nop(); pm = nop(); pw = nop();
        m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic m_advance(input ins_t id, input logic pc);
        logic lu;
        lu = m_lu(id);
        if (pc && m_fcnt < CMAX) m_fcnt++;
        if (!pc && lu && m_scnt < CMAX) m_scnt++;
        pw = pm;
        pm = pc ? nop() : pe;
        pe = (pc || lu) ? nop() : id;
    endtask

    function automatic logic [4:0] dut_ctl();
        return {hz.stall_F, hz.stall_D, hz.flush_D, hz.flush_E, hz.flush_M};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input ins_t id, input logic pc);
        hz.id_valid    = id.v;
        hz.id_rn       = id.rn;
        hz.id_rm       = id.rm;
        hz.id_uses_rm  = id.urm;
        hz.id_rd       = id.rd;
        hz.id_regwrite = id.rw;
        hz.id_memread  = id.mr;
        hz.mem_pcsrc   = pc;
    endtask

    task automatic chk_all(input string tag, input logic [4:0] ctl, input logic [1:0] fa,
                           input logic [1:0] fb, input int sc, input int fc);
        chk({tag, "_ctl"}, 32'(dut_ctl()), 32'(ctl));
        chk({tag, "_fwd_a"}, 32'(hz.fwd_a), 32'(fa));
        chk({tag, "_fwd_b"}, 32'(hz.fwd_b), 32'(fb));
        chk({tag, "_stall_cnt"}, 32'(hz.stall_cnt), 32'(sc));
        chk({tag, "_flush_cnt"}, 32'(hz.flush_cnt), 32'(fc));
    endtask

    // Assert reset away from the clock edge, check it took effect at once, then release.
    task automatic async_reset(input string tag);
        drive(nop(), 1'b0);
        #2 reset = 1'b1;
        #1 chk_all(tag, 5'b0, 2'b00, 2'b00, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input ins_t id, input logic pc, input logic [4:0] ctl,
                           input logic [1:0] fa, input logic [1:0] fb,
                           input int sc, input int fc);
        vec_t v;
        v.id = id; v.pc = pc; v.ctl = ctl; v.fa = fa; v.fb = fb; v.scnt = sc; v.fcnt = fc;
        tbl.push_back(v);
    endtask

    initial begin
        ins_t add_x1, ld_x1, add_x2;
        add_x1 = mk(1, 2, 3, 1, 1, 1, 0);          // ADD X1,X2,X3
        ld_x1  = mk(1, 2, 0, 0, 1, 1, 1);          // LDUR X1,[X2]
        add_x2 = mk(1, 1, 1, 1, 2, 1, 0);          // ADD X2,X1,X1

        // MEM->EX forward, WB->EX forward, double producer, load-use, XZR, branch over load-use
        add_vec(add_x1,                    0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(mk(1, 1, 5, 1, 4, 1, 0),   0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(nop(),                     0, 5'b00000, 2'b10, 2'b00, 0, 0);
        add_vec(nop(),                     0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(add_x1,                    0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(nop(),                     0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(mk(1, 7, 1, 1, 6, 1, 0),   0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(nop(),                     0, 5'b00000, 2'b00, 2'b01, 0, 0);
        add_vec(add_x1,                    0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(add_x1,                    0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(mk(1, 1, 1, 1, 8, 1, 0),   0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(nop(),                     0, 5'b00000, 2'b10, 2'b10, 0, 0);
        add_vec(ld_x1,                     0, 5'b00000, 2'b00, 2'b00, 0, 0);
        add_vec(add_x2,                    0, 5'b11010, 2'b00, 2'b00, 0, 0);
        add_vec(add_x2,                    0, 5'b00000, 2'b00, 2'b00, 1, 0);
        add_vec(nop(),                     0, 5'b00000, 2'b01, 2'b01, 1, 0);
        add_vec(mk(1, 3, 4, 1, 31, 1, 0),  0, 5'b00000, 2'b00, 2'b00, 1, 0);
        add_vec(mk(1, 2, 0, 0, 31, 1, 1),  0, 5'b00000, 2'b00, 2'b00, 1, 0);
        add_vec(mk(1, 31, 31, 1, 5, 1, 0), 0, 5'b00000, 2'b00, 2'b00, 1, 0);
        add_vec(mk(1, 31, 7, 1, 6, 1, 0),  0, 5'b00000, 2'b00, 2'b00, 1, 0);
        add_vec(nop(),                     0, 5'b00000, 2'b00, 2'b00, 1, 0);
        add_vec(mk(1, 2, 0, 0, 9, 1, 1),   0, 5'b00000, 2'b00, 2'b00, 1, 0);
        add_vec(mk(1, 9, 9, 1, 10, 1, 0),  1, 5'b00111, 2'b00, 2'b00, 1, 0);
        add_vec(nop(),                     0, 5'b00000, 2'b00, 2'b00, 1, 1);
        add_vec(nop(),                     1, 5'b00111, 2'b00, 2'b00, 1, 1);
        add_vec(nop(),                     0, 5'b00000, 2'b00, 2'b00, 1, 2);

        reset = 1'b1;
        drive(nop(), 1'b0);
        #3 chk_all("por", 5'b0, 2'b00, 2'b00, 0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            ins_t id;
            logic pc;
            id = rnd_ins();
            pc = ($urandom_range(0, 7) == 0);
            drive(id, pc);
            @(negedge clk);
            chk_all($sformatf("rnd%0d", n), m_ctl(id, pc), m_fwd(pe.rn), m_fwd(pe.rm),
                    m_scnt, m_fcnt);
            @(posedge clk);
            m_advance(id, pc);
            #1;
        end

        async_reset("midrst");

        foreach (tbl[i]) begin
            drive(tbl[i].id, tbl[i].pc);
            @(negedge clk);
            chk_all($sformatf("t%0d", i), tbl[i].ctl, tbl[i].fa, tbl[i].fb,
                    tbl[i].scnt, tbl[i].fcnt);
            @(posedge clk);
            #1;
        end

        // Long branch storm: flush_cnt must stop at all-ones instead of wrapping.
        async_reset("satrst");
        drive(ld_x1, 1'b1);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre", 32'(hz.flush_cnt), 32'h0000_FFFE);
        chk("sat_ctl", 32'(dut_ctl()), 32'(5'b00111));
        @(posedge clk);
        #1;
        chk("sat_hit", 32'(hz.flush_cnt), 32'h0000_FFFF);
        repeat (4) @(posedge clk);
        #1;
        chk("sat_hold", 32'(hz.flush_cnt), 32'h0000_FFFF);
        chk("sat_stall", 32'(hz.stall_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
